// File: rtl/vedic_mul_pipe.sv
// Purpose : signed/unsigned WIDTH x WIDTH -> 2*WIDTH multiplier built from 8x8 Urdhva-Tiryakbhyam tiles.
// Latency : 3 stages; the result appears after the third rising edge counted from the accepting edge; 1 result/cycle.
// Backpr. : a single enable (!out_valid || out_ready) freezes every stage; in_ready is that enable.
//
// Ports   : clk/rst_n (sync, active-low); in_valid/in_ready + operand_a/operand_b/op_mode/in_tag
//           on the input side; out_valid/out_ready + result/out_tag on the output side;
//           op_count (32-bit completed-result counter) only when VEDIC_MUL_CNT_EN is defined.
// op_mode : [0]=1 treats operand_a as signed, [1]=1 treats operand_b as signed.
module vedic_mul_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    input  logic [1:0]           op_mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [TAG_W-1:0]     out_tag
`ifdef VEDIC_MUL_CNT_EN
    ,
    output logic [31:0]          op_count
`endif
);
    localparam int NT = WIDTH / 8;
    localparam int PW = 2 * WIDTH;

    generate
        if (WIDTH != 8 && WIDTH != 16 && WIDTH != 32 && WIDTH != 64) begin : g_bad_width
            $error("vedic_mul_pipe: WIDTH must be 8, 16, 32 or 64");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("vedic_mul_pipe: TAG_W must be at least 1");
        end
    endgenerate

    // 8x8 vertical-and-crosswise tile: column k sums every bit pair whose indices add to k.
    function automatic logic [15:0] vedic8(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] acc;
        logic [3:0]  col;
        acc = '0;
        for (int k = 0; k < 15; k++) begin
            col = '0;
            for (int i = 0; i < 8; i++) begin
                if (k >= i && (k - i) <= 7) begin
                    col = col + {3'b000, x[i] & y[3'(k - i)]};
                end
            end
            acc = acc + ({12'd0, col} << k);
        end
        return acc;
    endfunction

    // Kogge-Stone parallel-prefix adder, modulo 2^PW.
    function automatic logic [PW-1:0] ks_add(input logic [PW-1:0] x, input logic [PW-1:0] y);
        logic [PW-1:0] g;
        logic [PW-1:0] p;
        logic [PW-1:0] p0;
        logic [PW-1:0] gn;
        logic [PW-1:0] pn;
        g  = x & y;
        p  = x ^ y;
        p0 = p;
        for (int d = 1; d < PW; d = d * 2) begin
            gn = g | (p & (g << d));
            pn = p & (p << d);
            g  = gn;
            p  = pn;
        end
        return p0 ^ (g << 1);
    endfunction

    logic                 w_en;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_sign;
    logic [PW-1:0]        w_pp;
    logic [PW-1:0]        w_t;
    logic [PW-1:0]        w_s;
    logic [PW-1:0]        w_c;
    logic [PW-1:0]        w_mag;
    logic [PW-1:0]        w_res;

    logic                 r_v1;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_sign1;
    logic [TAG_W-1:0]     r_tag1;
    logic                 r_v2;
    logic [PW-1:0]        r_s;
    logic [PW-1:0]        r_c;
    logic                 r_sign2;
    logic [TAG_W-1:0]     r_tag2;
    logic                 r_v3;
    logic [PW-1:0]        r_res;
    logic [TAG_W-1:0]     r_tag3;

    assign w_en = !r_v3 || out_ready;

    // The most negative value negates to itself, which is exactly its unsigned magnitude.
    assign w_a_neg = op_mode[0] & operand_a[WIDTH-1];
    assign w_b_neg = op_mode[1] & operand_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~operand_a + 1'b1) : operand_a;
    assign w_b_mag = w_b_neg ? (~operand_b + 1'b1) : operand_b;
    // A zero operand forces a positive sign so a negative zero can never be produced.
    assign w_sign  = (w_a_neg ^ w_b_neg) & (operand_a != '0) & (operand_b != '0);

    // Tile products folded through a 3:2 compressor chain. Carries shifted past bit PW-1
    // are dropped safely: the true magnitude fits in PW bits, so sum+carry stays exact mod 2^PW.
    always_comb begin
        w_s  = '0;
        w_c  = '0;
        w_pp = '0;
        w_t  = '0;
        for (int i = 0; i < NT; i++) begin
            for (int j = 0; j < NT; j++) begin
                w_pp = PW'(vedic8(r_a[8*i +: 8], r_b[8*j +: 8])) << (8 * (i + j));
                w_t  = w_s ^ w_c ^ w_pp;
                w_c  = ((w_s & w_c) | (w_s & w_pp) | (w_c & w_pp)) << 1;
                w_s  = w_t;
            end
        end
    end

    assign w_mag = ks_add(r_s, r_c);
    assign w_res = r_sign2 ? (~w_mag + 1'b1) : w_mag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sign1 <= 1'b0;
            r_tag1  <= '0;
            r_v2    <= 1'b0;
            r_s     <= '0;
            r_c     <= '0;
            r_sign2 <= 1'b0;
            r_tag2  <= '0;
            r_v3    <= 1'b0;
            r_res   <= '0;
            r_tag3  <= '0;
        end else if (w_en) begin
            r_v1    <= in_valid;
            r_a     <= w_a_mag;
            r_b     <= w_b_mag;
            r_sign1 <= w_sign;
            r_tag1  <= in_tag;
            r_v2    <= r_v1;
            r_s     <= w_s;
            r_c     <= w_c;
            r_sign2 <= r_sign1;
            r_tag2  <= r_tag1;
            r_v3    <= r_v2;
            r_res   <= w_res;
            r_tag3  <= r_tag2;
        end
    end

    assign in_ready  = w_en;
    assign out_valid = r_v3;
    assign result    = r_res;
    assign out_tag   = r_tag3;

`ifdef VEDIC_MUL_CNT_EN
    logic [31:0] r_cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_v3 && out_ready) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end
    assign op_count = r_cnt;
`endif

endmodule

// File: tb/tb_vedic_mul_pipe.sv
module tb_vedic_mul_pipe;
    localparam int W  = 16;
    localparam int TW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            in_valid;
    logic            out_ready;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [1:0]      mode;
    logic [TW-1:0]   tag;
    logic            in_ready;
    logic            out_valid;
    logic [2*W-1:0]  result;
    logic [TW-1:0]   out_tag;
`ifdef VEDIC_MUL_CNT_EN
    logic [31:0]     op_count;
`endif

    vedic_mul_pipe #(.WIDTH(W), .TAG_W(TW)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(a), .operand_b(b), .op_mode(mode), .in_tag(tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag)
`ifdef VEDIC_MUL_CNT_EN
        , .op_count(op_count)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: interpret each operand per mode as a plain integer, multiply, reduce mod 2^(2w).
    function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                             input logic [1:0] m, input int w);
        logic signed [129:0] sx;
        logic signed [129:0] sy;
        logic signed [129:0] p;
        logic [129:0]        msk;
        sx = $signed({66'd0, x});
        sy = $signed({66'd0, y});
        if (m[0] && x[w-1]) sx = sx - (130'sd1 <<< w);
        if (m[1] && y[w-1]) sy = sy - (130'sd1 <<< w);
        p   = sx * sy;
        msk = (130'd1 << (2 * w)) - 130'd1;
        return 128'(p & msk);
    endfunction

    typedef struct {
        logic [127:0]  res;
        logic [TW-1:0] tag;
        int            cyc;
    } ent_t;

    ent_t exp_q[$];
    ent_t out_log[$];
    int   n_out = 0;
    int   cyc   = 0;

    // Scoreboard: every accepted operand pair queues its product; every out transfer retires one.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            n_out = 0;
        end else begin
            if (out_valid && out_ready) begin
                out_log.push_back('{128'(result), out_tag, cyc});
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n_out++;
            end
            if (in_valid && in_ready) exp_q.push_back('{ref_mul(64'(a), 64'(b), mode, W), tag, 0});
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) chk("unexpected_out", 128'(out_valid), 128'd0);
                else begin
                    chk("result", 128'(result), exp_q[0].res);
                    chk("out_tag", 128'(out_tag), 128'(exp_q[0].tag));
                end
            end
            chk("in_ready", 128'(in_ready), 128'(!out_valid || out_ready));
`ifdef VEDIC_MUL_CNT_EN
            chk("op_count", 128'(op_count), 128'(n_out));
`endif
        end
    end

    // Width sweep: corner operands {0, 1, max, min-negative} through 8/32/64-bit instances.
    logic          sw_vld = 1'b0;
    logic [1:0]    sw_ia  = '0;
    logic [1:0]    sw_ib  = '0;
    logic [1:0]    sw_mode = '0;
    logic [TW-1:0] sw_tag = '0;

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int SW = (g == 0) ? 8 : (g == 1) ? 32 : 64;
        logic [SW-1:0]   sa;
        logic [SW-1:0]   sb;
        logic            sir;
        logic            sov;
        logic [2*SW-1:0] sres;
        logic [TW-1:0]   stag;
`ifdef VEDIC_MUL_CNT_EN
        logic [31:0]     scnt;
`endif
        logic [131:0]    sq[$];

        function automatic logic [SW-1:0] cnr(input logic [1:0] i);
            logic [SW-1:0] v;
            case (i)
                2'd0:    v = '0;
                2'd1:    v = SW'(1);
                2'd2:    v = '1;
                default: v = {1'b1, {(SW-1){1'b0}}};
            endcase
            return v;
        endfunction

        assign sa = cnr(sw_ia);
        assign sb = cnr(sw_ib);

        vedic_mul_pipe #(.WIDTH(SW), .TAG_W(TW)) u_sw (
            .clk(clk), .rst_n(rst_n), .in_valid(sw_vld), .in_ready(sir),
            .operand_a(sa), .operand_b(sb), .op_mode(sw_mode), .in_tag(sw_tag),
            .out_valid(sov), .out_ready(1'b1), .result(sres), .out_tag(stag)
`ifdef VEDIC_MUL_CNT_EN
            , .op_count(scnt)
`endif
        );

        always @(posedge clk) begin
            if (!rst_n) sq.delete();
            else begin
                if (sov && sq.size() > 0) void'(sq.pop_front());
                if (sw_vld && sir) sq.push_back({sw_tag, ref_mul(64'(sa), 64'(sb), sw_mode, SW)});
            end
        end

        always @(negedge clk) begin
            if (chk_en && rst_n && sov) begin
                if (sq.size() == 0) chk($sformatf("sweep_w%0d_unexpected", SW), 128'(sov), 128'd0);
                else begin
                    chk($sformatf("sweep_w%0d_result", SW), 128'(sres), sq[0][127:0]);
                    chk($sformatf("sweep_w%0d_tag", SW), 128'(stag), 128'(sq[0][131:128]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string nm);
        int gd = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && gd < 40) begin
            step();
            gd++;
        end
        chk(nm, 128'(exp_q.size()), 128'd0);
        step();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return W'(1);
            2:       return '1;
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    logic [W-1:0]   a2[4]   = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h0000};
    logic [W-1:0]   b2[4]   = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000};
    logic [1:0]     m2[4]   = '{2'b11, 2'b01, 2'b11, 2'b10};
    logic [127:0]   exp2[4] = '{128'h1, 128'hFFFF_0001, 128'h4000_0000, 128'h0};
    logic [2*W-1:0] snap_r;
    logic [TW-1:0]  snap_t;

    initial begin
        int lat;
        int gd;
        int nv;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; mode = '0; tag = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_result", 128'(result), 128'd0);
        chk("reset_out_tag", 128'(out_tag), 128'd0);
        chk("reset_in_ready", 128'(in_ready), 128'd1);
`ifdef VEDIC_MUL_CNT_EN
        chk("reset_op_count", 128'(op_count), 128'd0);
`endif
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Pin the reference model with hand-computed products.
        chk("model_uu", ref_mul(64'hFFFF, 64'hFFFF, 2'b00, 16), 128'hFFFE_0001);
        for (int k = 0; k < 4; k++)
            chk($sformatf("model_t2_%0d", k), ref_mul(64'(a2[k]), 64'(b2[k]), m2[k], 16), exp2[k]);
        chk("model_w64_minmin", ref_mul(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 64),
            128'h4000_0000_0000_0000_0000_0000_0000_0000);
        chk("model_w8_mixed", ref_mul(64'hFF, 64'h80, 2'b01, 8), 128'h0000_0000_0000_0000_0000_0000_0000_FF80);

        // 1: unsigned max*max, latency counted from the accepting edge.
        a = 16'hFFFF; b = 16'hFFFF; mode = 2'b00; tag = 4'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk("t1_latency", 128'(lat), 128'd3);
        chk("t1_result", 128'(result), 128'hFFFE_0001);
        chk("t1_tag", 128'(out_tag), 128'd3);
        drain("t1_drain");

        // 2: signed modes back-to-back; four results on consecutive cycles, in order.
        out_log.delete();
        for (int k = 0; k < 4; k++) begin
            a = a2[k]; b = b2[k]; mode = m2[k]; tag = TW'(k); in_valid = 1'b1;
            step();
        end
        drain("t2_drain");
        chk("t2_count", 128'(out_log.size()), 128'd4);
        if (out_log.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("t2_result_%0d", k), out_log[k].res, exp2[k]);
                chk($sformatf("t2_tag_%0d", k), 128'(out_log[k].tag), 128'(k));
                chk($sformatf("t2_cycle_%0d", k), 128'(out_log[k].cyc - out_log[0].cyc), 128'(k));
            end
        end

        // 3: six ops with a 5-cycle output stall once the first result is up.
        out_log.delete();
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    a = W'($urandom); b = W'($urandom); mode = 2'(k); tag = TW'(4 + k);
                    in_valid = 1'b1;
                    gd = 0;
                    while (!in_ready && gd < 50) begin
                        step();
                        gd++;
                    end
                    step();
                end
                in_valid = 1'b0;
            end
            begin
                int g2;
                g2 = 0;
                while (!out_valid && g2 < 50) begin
                    @(posedge clk);
                    #1;
                    g2++;
                end
                chk("t3_out_valid_seen", 128'(out_valid), 128'd1);
                out_ready = 1'b0;
                snap_r = result;
                snap_t = out_tag;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    chk("t3_stall_in_ready", 128'(in_ready), 128'd0);
                    chk("t3_stall_out_valid", 128'(out_valid), 128'd1);
                    chk("t3_stall_result", 128'(result), 128'(snap_r));
                    chk("t3_stall_tag", 128'(out_tag), 128'(snap_t));
                end
                out_ready = 1'b1;
            end
        join
        drain("t3_drain");
        chk("t3_count", 128'(out_log.size()), 128'd6);
        for (int k = 0; k < 6 && k < out_log.size(); k++)
            chk($sformatf("t3_order_%0d", k), 128'(out_log[k].tag), 128'(4 + k));

        // 4: reset with three products in flight; none may resurface.
        for (int k = 0; k < 3; k++) begin
            a = W'($urandom); b = W'($urandom); mode = 2'(k); tag = TW'(10 + k); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("t4_out_valid", 128'(out_valid), 128'd0);
        chk("t4_result", 128'(result), 128'd0);
        chk("t4_out_tag", 128'(out_tag), 128'd0);
`ifdef VEDIC_MUL_CNT_EN
        chk("t4_op_count", 128'(op_count), 128'd0);
`endif
        rst_n = 1'b1;
        nv = 0;
        repeat (8) begin
            step();
            if (out_valid) nv++;
        end
        chk("t4_no_stale", 128'(nv), 128'd0);

        // 5: random traffic with random backpressure.
        for (int n = 0; n < 10000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = pick();
            b         = pick();
            mode      = 2'($urandom);
            tag       = TW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain("t5_drain");

        // 6: corner set in all modes at WIDTH 8/32/64.
        for (int m = 0; m < 4; m++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    sw_vld = 1'b1; sw_mode = 2'(m); sw_ia = 2'(i); sw_ib = 2'(j);
                    sw_tag = TW'(i * 4 + j);
                    step();
                end
        sw_vld = 1'b0;
        repeat (6) step();
        chk("t6_drain_w8", 128'(g_sw[0].sq.size()), 128'd0);
        chk("t6_drain_w32", 128'(g_sw[1].sq.size()), 128'd0);
        chk("t6_drain_w64", 128'(g_sw[2].sq.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at time %0t, expected to have finished", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
